// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared TMDS definitions used by both the transmit-side encoder and the
// receive-side symbol decoder:
//   - symbol width and the four control-period tokens CTRL_00..CTRL_11
//   - the alignment state type {SEARCH, LOCKED}
//   - helper functions for token classification and data-symbol decoding
// No ports (package).
// -----------------------------------------------------------------------------
package tmds_pkg;

  localparam int SYM_W = 10;

  // Control-period tokens, indexed by {C1,C0}.
  localparam logic [SYM_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_11 = 10'b1010101011;

  // Alignment FSM state, kept as plain constants so the encoding is fixed.
  typedef logic [0:0] align_state_t;
  localparam align_state_t SEARCH = 1'b0;
  localparam align_state_t LOCKED = 1'b1;

  // Counter width for a count limit; never narrower than one bit.
  function automatic int counter_width(input int limit);
    int w;
    if (limit > 1) begin
      w = $clog2(limit);
    end else begin
      w = 1;
    end
    return w;
  endfunction

  // True when the symbol is one of the four control tokens.
  function automatic logic is_ctrl(input logic [SYM_W-1:0] sym);
    logic hit;
    case (sym)
      CTRL_00, CTRL_01, CTRL_10, CTRL_11: hit = 1'b1;
      default:                            hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Control bits {C1,C0} carried by a token; 00 for anything else.
  function automatic logic [1:0] ctrl_bits(input logic [SYM_W-1:0] sym);
    logic [1:0] c;
    case (sym)
      CTRL_00: c = 2'b00;
      CTRL_01: c = 2'b01;
      CTRL_10: c = 2'b10;
      CTRL_11: c = 2'b11;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  // Undo the DC-balance inversion (bit 9) and then the XOR/XNOR
  // transition chain (bit 8 selects XOR when set).
  function automatic logic [7:0] decode_data(input logic [SYM_W-1:0] sym);
    logic [7:0] d;
    logic [7:0] vd;
    if (sym[9]) begin
      d = ~sym[7:0];
    end else begin
      d = sym[7:0];
    end
    vd[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      if (sym[8]) begin
        vd[i] = d[i] ^ d[i-1];
      end else begin
        vd[i] = ~(d[i] ^ d[i-1]);
      end
    end
    return vd;
  endfunction

endpackage

// File: rtl/tmds_symbol_decoder_align.sv
// -----------------------------------------------------------------------------
// tmds_symbol_align
// Finds the 10-bit symbol boundary in an unaligned deserializer stream.
// A 20-bit window {raw_word, previous word} is barrel-selected at the current
// offset into the stage-1 symbol register q. A SEARCH/LOCKED FSM counts runs
// of control tokens on q to declare lock, slips the offset after a search
// timeout, and drops lock after a long stretch without any control token.
// Ports:
//   clk      in   pixel clock
//   rst      in   synchronous active-high reset
//   raw_word in   10-bit deserializer word, bit 0 received first
//   realign  in   one-cycle pulse: slip offset and restart search
//   q        out  aligned symbol (stage 1 register)
//   locked   out  1 while in LOCKED
//   offset   out  current bit offset 0..9
// -----------------------------------------------------------------------------
module tmds_symbol_align
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN_MIN   = 16,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] raw_word,
  input  logic             realign,
  output logic [SYM_W-1:0] q,
  output logic             locked,
  output logic [3:0]       offset
);

  localparam int RUN_W   = counter_width(CTRL_RUN_MIN);
  localparam int TIMER_W = counter_width(SEARCH_TIMEOUT);
  localparam int GAP_W   = counter_width(LOCK_TIMEOUT);

  // Terminal values are compared before incrementing, so each counter only
  // ever needs to hold limit-1.
  localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(CTRL_RUN_MIN - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SEARCH_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(LOCK_TIMEOUT - 1);

  logic [SYM_W-1:0]   prev_r;
  logic [SYM_W-1:0]   q_r;
  align_state_t       state_r;
  logic [3:0]         offset_r;
  logic [RUN_W-1:0]   run_cnt_r;
  logic [TIMER_W-1:0] timer_r;
  logic [GAP_W-1:0]   gap_cnt_r;

  logic [2*SYM_W-1:0] window_s;
  logic [SYM_W-1:0]   aligned_s;
  logic [3:0]         next_offset_s;
  logic               ctrl_s;

  assign window_s = {raw_word, prev_r};
  assign ctrl_s   = is_ctrl(q_r);

  // Barrel select of the 10-bit symbol starting at the current offset.
  always_comb begin
    aligned_s = window_s[9:0];
    case (offset_r)
      4'd0:    aligned_s = window_s[9:0];
      4'd1:    aligned_s = window_s[10:1];
      4'd2:    aligned_s = window_s[11:2];
      4'd3:    aligned_s = window_s[12:3];
      4'd4:    aligned_s = window_s[13:4];
      4'd5:    aligned_s = window_s[14:5];
      4'd6:    aligned_s = window_s[15:6];
      4'd7:    aligned_s = window_s[16:7];
      4'd8:    aligned_s = window_s[17:8];
      4'd9:    aligned_s = window_s[18:9];
      default: aligned_s = window_s[9:0];
    endcase
  end

  // Offset after a bit slip, wrapping 9 back to 0.
  always_comb begin
    if (offset_r == 4'd9) begin
      next_offset_s = 4'd0;
    end else begin
      next_offset_s = offset_r + 4'd1;
    end
  end

  // Window capture, stage-1 symbol register and the alignment FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r    <= '0;
      q_r       <= '0;
      state_r   <= SEARCH;
      offset_r  <= 4'd0;
      run_cnt_r <= '0;
      timer_r   <= '0;
      gap_cnt_r <= '0;
    end else begin
      prev_r <= raw_word;
      q_r    <= aligned_s;
      if (realign) begin
        // Explicit request wins over lock detection and both timeouts.
        state_r   <= SEARCH;
        offset_r  <= next_offset_s;
        run_cnt_r <= '0;
        timer_r   <= '0;
        gap_cnt_r <= '0;
      end else begin
        case (state_r)
          SEARCH: begin
            gap_cnt_r <= '0;
            if (ctrl_s && (run_cnt_r == RUN_LAST)) begin
              state_r   <= LOCKED;
              run_cnt_r <= '0;
              timer_r   <= '0;
            end else if (timer_r == TIMER_LAST) begin
              offset_r  <= next_offset_s;
              run_cnt_r <= '0;
              timer_r   <= '0;
            end else begin
              if (ctrl_s) begin
                run_cnt_r <= run_cnt_r + RUN_W'(1);
              end else begin
                run_cnt_r <= '0;
              end
              timer_r <= timer_r + TIMER_W'(1);
            end
          end
          LOCKED: begin
            run_cnt_r <= '0;
            timer_r   <= '0;
            if (ctrl_s) begin
              gap_cnt_r <= '0;
            end else if (gap_cnt_r == GAP_LAST) begin
              // Offset is kept so the new search starts where lock was lost.
              state_r   <= SEARCH;
              gap_cnt_r <= '0;
            end else begin
              gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            end
          end
          default: begin
            state_r   <= SEARCH;
            run_cnt_r <= '0;
            timer_r   <= '0;
            gap_cnt_r <= '0;
          end
        endcase
      end
    end
  end

  assign q      = q_r;
  assign locked = (state_r == LOCKED);
  assign offset = offset_r;

endmodule

// File: rtl/tmds_symbol_decoder.sv
// -----------------------------------------------------------------------------
// tmds_symbol_decoder
// Per-channel TMDS receive decoder. Aligns the raw deserializer words to the
// symbol boundary (tmds_symbol_align) and decodes each aligned symbol into
// video data, control bits and a data-enable in a registered output stage.
// raw_word sampled at edge k appears on the outputs after edge k+2.
// Ports:
//   clk      in   pixel clock (deserializer core clock)
//   rst      in   synchronous active-high reset
//   raw_word in   10-bit deserializer word, bit 0 received first
//   realign  in   one-cycle pulse: slip offset and restart search
//   VD       out  decoded video data
//   CD       out  decoded control bits {C1,C0}
//   VDE      out  1 = VD valid, 0 = blanking/control
//   locked   out  symbol alignment established
//   offset   out  current alignment offset 0..9
// -----------------------------------------------------------------------------
module tmds_symbol_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN_MIN   = 16,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOCK_TIMEOUT   = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] raw_word,
  input  logic             realign,
  output logic [7:0]       VD,
  output logic [1:0]       CD,
  output logic             VDE,
  output logic             locked,
  output logic [3:0]       offset
);

  logic [SYM_W-1:0] q_s;
  logic             locked_s;
  logic [3:0]       offset_s;

  logic [7:0] vd_r;
  logic [1:0] cd_r;
  logic       vde_r;

  tmds_symbol_align #(
    .CTRL_RUN_MIN   (CTRL_RUN_MIN),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT)
  ) u_align (
    .clk      (clk),
    .rst      (rst),
    .raw_word (raw_word),
    .realign  (realign),
    .q        (q_s),
    .locked   (locked_s),
    .offset   (offset_s)
  );

  // Stage-2 output register: decode the aligned symbol when locked.
  always_ff @(posedge clk) begin
    if (rst) begin
      vd_r  <= 8'h00;
      cd_r  <= 2'b00;
      vde_r <= 1'b0;
    end else if (locked_s) begin
      if (is_ctrl(q_s)) begin
        vd_r  <= 8'h00;
        cd_r  <= ctrl_bits(q_s);
        vde_r <= 1'b0;
      end else begin
        // CD keeps the last control value through the active period.
        vd_r  <= decode_data(q_s);
        cd_r  <= cd_r;
        vde_r <= 1'b1;
      end
    end else begin
      vd_r  <= 8'h00;
      cd_r  <= 2'b00;
      vde_r <= 1'b0;
    end
  end

  assign VD     = vd_r;
  assign CD     = cd_r;
  assign VDE    = vde_r;
  assign locked = locked_s;
  assign offset = offset_s;

endmodule
